// File: rtl/ram_wr_ctrl_if.sv
// Write-port bundle between ram_wr_ctrl and the RAM / read-side controller.
// The master side is the write controller; the slave side is its environment.
interface ram_wr_ctrl_if #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 5
) ();

   logic              pause;
   logic              rd_done;
   logic              ram_wr_en;
   logic [ADDR_W-1:0] ram_wr_addr;
   logic [DATA_W-1:0] ram_wr_data;
   logic              wr_done;
   logic [DATA_W-1:0] pass_cnt;

   modport master (
      input  pause,
      input  rd_done,
      output ram_wr_en,
      output ram_wr_addr,
      output ram_wr_data,
      output wr_done,
      output pass_cnt
   );

   modport slave (
      output pause,
      output rd_done,
      input  ram_wr_en,
      input  ram_wr_addr,
      input  ram_wr_data,
      input  wr_done,
      input  pass_cnt
   );

endinterface

// File: rtl/ram_wr_ctrl.sv
// Port-A write controller: fills the RAM with an incrementing pattern, flags the
// pass as done, and refills with the next offset once the reader acknowledges.
module ram_wr_ctrl #(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned ADDR_W    = 5,
   parameter int unsigned DEPTH     = 32,
   parameter int unsigned START_DLY = 10
) (
   input  logic          clk,
   input  logic          rst_n,
   ram_wr_ctrl_if.master wr_if
);

   // One extra index bit so the index can reach DEPTH when DEPTH = 2^ADDR_W.
   localparam int unsigned IdxW = ADDR_W + 1;
   localparam int unsigned CntW = (START_DLY > 1) ? $clog2(START_DLY) : 1;

   typedef enum logic [1:0] {StWait, StWrite, StDone} state_e;

   state_e            state_q;
   logic [CntW-1:0]   dly_q;
   logic [IdxW-1:0]   idx_q;
   logic [DATA_W-1:0] offset_q;
   logic [DATA_W-1:0] pass_q;
   logic              en_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] data_q;
   logic              done_q;
   logic [DATA_W-1:0] data_d;

   always_comb begin
      data_d = DATA_W'(idx_q) + offset_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StWait;
         dly_q    <= '0;
         idx_q    <= '0;
         offset_q <= '0;
         pass_q   <= '0;
         en_q     <= 1'b0;
         addr_q   <= '0;
         data_q   <= '0;
         done_q   <= 1'b0;
      end else begin
         case (state_q)
            StWait: begin
               if (dly_q == CntW'(START_DLY - 1)) begin
                  state_q <= StWrite;
                  dly_q   <= '0;
               end else begin
                  dly_q <= dly_q + CntW'(1);
               end
            end
            StWrite: begin
               // The edge after the final write closes the pass, whatever pause says.
               if (idx_q == IdxW'(DEPTH)) begin
                  state_q <= StDone;
                  en_q    <= 1'b0;
                  addr_q  <= '0;
                  data_q  <= '0;
                  done_q  <= 1'b1;
                  pass_q  <= pass_q + DATA_W'(1);
               end else if (!wr_if.pause) begin
                  en_q   <= 1'b1;
                  addr_q <= idx_q[ADDR_W-1:0];
                  data_q <= data_d;
                  idx_q  <= idx_q + IdxW'(1);
               end else begin
                  en_q <= 1'b0;
               end
            end
            StDone: begin
               if (wr_if.rd_done) begin
                  state_q  <= StWrite;
                  done_q   <= 1'b0;
                  offset_q <= offset_q + DATA_W'(1);
                  idx_q    <= '0;
               end
            end
            default: state_q <= StWait;
         endcase
      end
   end

   assign wr_if.ram_wr_en   = en_q;
   assign wr_if.ram_wr_addr = addr_q;
   assign wr_if.ram_wr_data = data_q;
   assign wr_if.wr_done     = done_q;
   assign wr_if.pass_cnt    = pass_q;

endmodule

// File: doc/ram_wr_ctrl.md
Name: ram_wr_ctrl

Overview:
- Write-side controller that drives port A (write port) of the simple dual-port RAM stage in the ip_2port_ram design.
- After reset it fills the RAM with a known incrementing pattern. It then raises a done flag and waits for the read-side controller to acknowledge consumption. After the acknowledgement it refills the RAM with the next pattern offset.
- It is the upstream producer for the RAM; its outputs connect directly to the RAM wren/wraddress/data pins.

Parameters:
- DATA_W, 8, width of RAM data word.
- ADDR_W, 5, width of RAM write address.
- DEPTH, 32, number of words written per pass. Legal range is 1..2^ADDR_W.
- START_DLY, 10, idle clock cycles after reset release before the first write. Legal minimum is 1.

Ports:
- clk  input  1  system clock (50 MHz in the top).
- rst_n  input  1  reset. Asynchronous assert, active-low.
- pause  input  1  level. While high, writing is suspended.
- rd_done  input  1  single-cycle pulse from the read controller: the buffer has been consumed.
- ram_wr_en  output  1  RAM write enable (registered).
- ram_wr_addr  output  ADDR_W  RAM write address (registered).
- ram_wr_data  output  DATA_W  RAM write data (registered).
- wr_done  output  1  level. High while a complete pass is held in the RAM and not yet acknowledged.
- pass_cnt  output  DATA_W  number of completed passes, modulo 2^DATA_W.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to WAIT.
  - Delay counter = 0, offset = 0.
  - ram_wr_en = 0, ram_wr_addr = 0, ram_wr_data = 0, wr_done = 0, pass_cnt = 0.
  - A reset in any state aborts the pass immediately. The next pass restarts at address 0 with offset 0. Partially written RAM contents are not cleared.
- All other logic is synchronous to the rising edge of clk. Every output is a flop.
- State machine:
  - WAIT:
    - The delay counter increments each cycle.
    - When the counter reaches START_DLY-1, go to WRITE and clear the counter.
    - ram_wr_en stays 0.
    - Net effect: the first ram_wr_en = 1 appears START_DLY+1 rising edges after rst_n rises.
  - WRITE:
    - Each cycle with pause = 0: ram_wr_en = 1, ram_wr_addr = current index i, ram_wr_data = (i + offset) mod 2^DATA_W. Then i increments.
    - Cycle with pause = 1: ram_wr_en = 0. ram_wr_addr and ram_wr_data hold their last values. i does not advance.
    - After the write of i = DEPTH-1, the next edge enters DONE.
    - Exactly DEPTH write-enable cycles occur per pass, regardless of pauses.
  - DONE:
    - ram_wr_en = 0. ram_wr_addr = 0 and ram_wr_data = 0 are driven from entry.
    - wr_done = 1, asserted on the first DONE cycle.
    - pass_cnt increments by 1 on the entry edge.
    - When rd_done = 1: wr_done clears on the next edge, offset increments by 1 (mod 2^DATA_W), i resets to 0, and the state goes to WRITE without a START_DLY delay.
- Handshake rules:
  - rd_done is sampled only in DONE. Pulses in WAIT or WRITE are ignored and are not latched.
  - pause is sampled only in WRITE. In DONE it is ignored.
  - A rd_done held high for several cycles is treated as one acknowledge. The refill begins on the next edge, and in WRITE rd_done has no effect.
  - If pause = 1 on the first WRITE cycle after acknowledge, no write occurs until pause falls.
- Boundaries:
  - DEPTH = 2^ADDR_W: the address reaches the all-ones value and then DONE is entered. The address never wraps within a pass.
  - Offset and pass_cnt wrap from 2^DATA_W-1 to 0.
  - Data values wrap mod 2^DATA_W. For example, i = 31 with offset 250 gives data 25 (DATA_W = 8).
  - Latency from rd_done to the first new write is 1 cycle: rd_done at edge n, ram_wr_en = 1 after edge n+1.

Test Plan:
- Reset release with START_DLY = 4, DEPTH = 32, pause = 0 → ram_wr_en rises 5 edges after rst_n rises. Writes cover addr 0..31 with data 0..31 over 32 consecutive cycles. wr_done = 1 and pass_cnt = 1 the cycle after addr 31.
- pause = 1 for 3 cycles at addr 10 → ram_wr_en = 0 for those 3 cycles. addr holds at 10 and data at 10. Writing resumes at addr 11 / data 11. The total count of wr_en cycles is still 32.
- In DONE, a 1-cycle pulse on rd_done → wr_done = 0 next cycle. Second pass writes addr 0..31 with data 1..32. pass_cnt = 2 at the end of the pass.
- rd_done pulsed during WAIT and mid-WRITE → no effect. wr_done rises only at the end of the pass, and the pass stays at 32 writes.
- rst_n driven low mid-WRITE at addr 17, asynchronously between edges → all outputs are 0 immediately. After release, the START_DLY wait repeats and writing restarts at addr 0 with data 0.
- Run 256 passes with an auto-ack → pass_cnt wraps to 0. The pass with offset 250 writes data 250..255 then 0..25.
